// File: rtl/demux5_reg.sv
// Registered 1-to-5 demultiplexer: one producer word is parked in one of five
// holding slots until its consumer acks it. Optional DEMUX5_REG_CLEAR_ON_READ_EN zeroes a slot on consume.

module demux5_reg_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_wr,
    input  logic             i_rd,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // A same-cycle write beats the consume, so the slot stays occupied.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_rd && r_valid) begin
            r_valid <= 1'b0;
`ifdef DEMUX5_REG_CLEAR_ON_READ_EN
            r_data  <= '0;
`endif
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

module demux5_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] entrada,
    input  logic [2:0]       controle,
    input  logic             escreve,
    input  logic [4:0]       lido,
    output logic [WIDTH-1:0] saida0,
    output logic [WIDTH-1:0] saida1,
    output logic [WIDTH-1:0] saida2,
    output logic [WIDTH-1:0] saida3,
    output logic [WIDTH-1:0] saida4,
    output logic [4:0]       valido,
    output logic             pronto,
    output logic             erro
);
    localparam int NUM_SLOTS = 5;

    logic [NUM_SLOTS-1:0][WIDTH-1:0] w_data;
    logic [NUM_SLOTS-1:0]            w_valid;
    logic [NUM_SLOTS-1:0]            w_free;
    logic [NUM_SLOTS-1:0]            w_sel;
    logic                            w_legal;
    logic                            w_tgt_free;
    logic                            w_accept;
    logic                            r_erro;

    assign w_legal = (controle <= 3'b100);
    // A full slot being acked this cycle counts as free (pass-through release).
    assign w_free  = ~w_valid | lido;

    always_comb begin
        w_tgt_free = 1'b0;
        w_sel      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (controle == 3'(i)) begin
                w_tgt_free = w_free[i];
                w_sel[i]   = 1'b1;
            end
        end
    end

    assign pronto   = w_legal & w_tgt_free;
    assign w_accept = escreve & pronto;

    genvar g;
    generate
        for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
            demux5_reg_slot #(.WIDTH(WIDTH)) u_slot (
                .clock   (clock),
                .reset   (reset),
                .i_wr    (w_accept & w_sel[g]),
                .i_rd    (lido[g]),
                .i_data  (entrada),
                .o_data  (w_data[g]),
                .o_valid (w_valid[g])
            );
        end
    endgenerate

    // Any write request that is not accepted is either illegal or an overflow.
    always_ff @(posedge clock) begin
        if (reset)
            r_erro <= 1'b0;
        else if (escreve && !pronto)
            r_erro <= 1'b1;
    end

    assign saida0 = w_data[0];
    assign saida1 = w_data[1];
    assign saida2 = w_data[2];
    assign saida3 = w_data[3];
    assign saida4 = w_data[4];
    assign valido = w_valid;
    assign erro   = r_erro;
endmodule
